// File: rtl/stream_popr_if.sv
// Handshake and data bundle for stream_popr: start/result handshakes plus input and output streams.
// The slave modport is the popr block itself; the master modport is whatever drives it.
interface stream_popr_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] dOut;
  logic [N-1:0] sIn;
  logic         sIn_valid;
  logic         sIn_ready;
  logic [N-1:0] sOut;
  logic         sOut_valid;
  logic         sOut_ready;

  modport master (
    output in_valid, out_ready, sIn, sIn_valid, sOut_ready,
    input  in_ready, out_valid, dOut, sIn_ready, sOut, sOut_valid
  );

  modport slave (
    input  in_valid, out_ready, sIn, sIn_valid, sOut_ready,
    output in_ready, out_valid, dOut, sIn_ready, sOut, sOut_valid
  );
endinterface

// File: rtl/stream_popr.sv
// Pops the first element of sIn after each start into dOut and forwards the rest to sOut.
// Define POPR_SKID_EN for a 2-entry tail skid buffer with registered sIn_ready; default is 1 entry.
module stream_popr #(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          nrst,
  stream_popr_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HEAD, PASS} state_t;

  state_t       state, state_nx;
  logic         in_ready_q, in_ready_nx;
  logic         out_valid_q, out_valid_nx;
  logic [N-1:0] dout_q, dout_nx;
  logic [N-1:0] sout_q, sout_nx;
  logic         sout_valid_q, sout_valid_nx;
  logic         sin_ready;
  logic         start, accept, pop, push, capture;

`ifdef POPR_SKID_EN
  logic [N-1:0] skid_q, skid_nx;
  logic         skid_valid_q, skid_valid_nx;
  logic         sin_ready_q, sin_ready_nx;

  assign sin_ready = sin_ready_q;
`else
  // Single slot: it can take a new element whenever it is empty or draining this cycle.
  assign sin_ready = (state == HEAD) || ((state == PASS) && (!sout_valid_q || bus.sOut_ready));
`endif

  assign start   = bus.in_valid & in_ready_q;
  assign accept  = bus.sIn_valid & sin_ready;
  assign pop     = sout_valid_q & bus.sOut_ready;
  assign push    = accept && (state == PASS);
  assign capture = accept && (state == HEAD);

  // NOTE: every variable gets its default first so the block stays purely combinational.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)   state_nx = HEAD;
      HEAD:    if (capture) state_nx = PASS;
      PASS:    if (start)   state_nx = HEAD;
      default:              state_nx = IDLE;
    endcase

    out_valid_nx = out_valid_q;
    if (capture)                         out_valid_nx = 1'b1;
    else if (out_valid_q && bus.out_ready) out_valid_nx = 1'b0;
    dout_nx = capture ? bus.sIn : dout_q;

    sout_nx       = sout_q;
    sout_valid_nx = sout_valid_q;
`ifdef POPR_SKID_EN
    skid_nx       = skid_q;
    skid_valid_nx = skid_valid_q;
    // The output register refills from the skid slot first so ordering is preserved.
    if (!sout_valid_q || pop) begin
      if (skid_valid_q) begin
        sout_nx       = skid_q;
        sout_valid_nx = 1'b1;
        skid_valid_nx = push;
        if (push) skid_nx = bus.sIn;
      end else begin
        sout_valid_nx = push;
        if (push) sout_nx = bus.sIn;
      end
    end else if (push) begin
      skid_nx       = bus.sIn;
      skid_valid_nx = 1'b1;
    end
    sin_ready_nx = (state_nx == HEAD) || ((state_nx == PASS) && !skid_valid_nx);
`else
    if (push) begin
      sout_nx       = bus.sIn;
      sout_valid_nx = 1'b1;
    end else if (pop) begin
      sout_valid_nx = 1'b0;
    end
`endif

    // A restart is only offered once the tail is drained and the previous head delivered.
    in_ready_nx = (state_nx == IDLE) ||
                  ((state_nx == PASS) && !sout_valid_nx && !out_valid_nx);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      dout_q       <= '0;
      sout_q       <= '0;
      sout_valid_q <= 1'b0;
`ifdef POPR_SKID_EN
      // NOTE: buffered data is cleared too, so no stale element can leak out after reset.
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      sin_ready_q  <= 1'b0;
`endif
    end else begin
      state        <= state_nx;
      in_ready_q   <= in_ready_nx;
      out_valid_q  <= out_valid_nx;
      dout_q       <= dout_nx;
      sout_q       <= sout_nx;
      sout_valid_q <= sout_valid_nx;
`ifdef POPR_SKID_EN
      skid_q       <= skid_nx;
      skid_valid_q <= skid_valid_nx;
      sin_ready_q  <= sin_ready_nx;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.dOut       = dout_q;
  assign bus.sIn_ready  = sin_ready;
  assign bus.sOut       = sout_q;
  assign bus.sOut_valid = sout_valid_q;

endmodule

// File: tb/tb_stream_popr.sv
// Bench for stream_popr: directed scenarios plus randomized traffic scored against a
// transaction-level model (head-pending flag, expected dOut, queue of expected sOut elements).
module tb_stream_popr;
  localparam int N = 8;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  stream_popr_if #(.N(N)) bus ();

  stream_popr #(.N(N)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_dout;
  logic         started, head_pending, dout_pending, expect_ov;
  logic         sstall, ostall;
  logic [N-1:0] sstall_val, ostall_val;
  logic         acc, st, spop, opop, acc_flag;
  int           n_sout_xfer = 0, n_out_xfer = 0, n_ov_cycles = 0, n_sov_cycles = 0;

  // Source counter: value presented on sIn, advanced after each accepted element
  logic [N-1:0] cnt;
  int           base;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Monitor/scoreboard: inputs only change just after posedge, so negedge sees the next handshake.
  always @(negedge clk) begin
    if (!nrst) begin
      exp_q.delete();
      started      = 1'b0;
      head_pending = 1'b0;
      dout_pending = 1'b0;
      expect_ov    = 1'b0;
      sstall       = 1'b0;
      ostall       = 1'b0;
      acc_flag     = 1'b0;
    end else begin
      acc  = bus.sIn_valid & bus.sIn_ready;
      st   = bus.in_valid & bus.in_ready;
      spop = bus.sOut_valid & bus.sOut_ready;
      opop = bus.out_valid & bus.out_ready;

      if (sstall) begin
        check("sout_hold_valid", int'(bus.sOut_valid), 1);
        check("sout_hold_data", int'(bus.sOut), int'(sstall_val));
      end
      if (ostall) begin
        check("dout_hold_valid", int'(bus.out_valid), 1);
        check("dout_hold_data", int'(bus.dOut), int'(ostall_val));
      end
      if (expect_ov) begin
        check("out_valid_after_head", int'(bus.out_valid), 1);
        check("dout_head_value", int'(bus.dOut), int'(exp_dout));
        expect_ov = 1'b0;
      end
      if (bus.in_ready)
        check("in_ready_when_drained", int'(exp_q.size() == 0 && !head_pending && !dout_pending), 1);

      if (spop) begin
        n_sout_xfer++;
        if (exp_q.size() == 0) check("sout_unexpected_element", int'(bus.sOut), -1);
        else                   check("sout_order", int'(bus.sOut), int'(exp_q.pop_front()));
      end
      if (opop) begin
        n_out_xfer++;
        check("dout_handshake_expected", int'(dout_pending), 1);
        check("dout_handshake_value", int'(bus.dOut), int'(exp_dout));
        dout_pending = 1'b0;
      end

      if (acc) begin
        if (!started) begin
          check("accept_before_start", 1, 0);
        end else if (head_pending) begin
          exp_dout     = bus.sIn;
          head_pending = 1'b0;
          dout_pending = 1'b1;
          expect_ov    = 1'b1;
        end else begin
          exp_q.push_back(bus.sIn);
        end
      end
      // A start coinciding with an accept only affects the element after it
      if (st) begin
        started      = 1'b1;
        head_pending = 1'b1;
      end

      acc_flag   = acc;
      sstall     = bus.sOut_valid & !bus.sOut_ready;
      sstall_val = bus.sOut;
      ostall     = bus.out_valid & !bus.out_ready;
      ostall_val = bus.dOut;
      if (bus.out_valid)  n_ov_cycles++;
      if (bus.sOut_valid) n_sov_cycles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc_flag) cnt++;
    bus.sIn = cnt;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.out_valid;
      1:       return bus.sOut_valid;
      default: return bus.in_ready;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string tag);
    int k = 0;
    while (!sig(which) && k < 50) begin
      tick();
      k++;
    end
    if (!sig(which)) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    nrst         = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_sout_valid", int'(bus.sOut_valid), 0);
    check("rst_sin_ready", int'(bus.sIn_ready), 0);
    check("rst_dout", int'(bus.dOut), 0);
    check("rst_sout", int'(bus.sOut), 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    nrst = 1'b1;
    tick();
    check("in_ready_after_release", int'(bus.in_ready), 1);
  endtask

  task automatic pulse_start();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.sIn        = '0;
    bus.sIn_valid  = 1'b0;
    bus.sOut_ready = 1'b1;
    cnt            = 8'd1;
    apply_reset();

    // Counting stream, everything ready: one head pulse, gap-free tail
    cnt = 8'd1; bus.sIn = cnt; bus.sIn_valid = 1'b1;
    base = n_out_xfer;
    pulse_start();
    wait_sig(1, "first_sout");
    check("first_sout_value", int'(bus.sOut), 2);
    begin
      int n0 = n_sout_xfer;
      repeat (20) tick();
      check("tail_gap_free", n_sout_xfer - n0, 20);
    end
    check("head_dout", int'(bus.dOut), 1);
    check("head_out_pulses", n_out_xfer - base, 1);

    // Same stream with out_ready held low: head stays, tail keeps flowing
    apply_reset();
    cnt = 8'd1; bus.sIn = cnt; bus.out_ready = 1'b0;
    base = n_ov_cycles;
    pulse_start();
    wait_sig(0, "held_head");
    begin
      int n0 = n_sout_xfer;
      repeat (5) tick();
      check("tail_unstalled", int'(n_sout_xfer - n0 >= 3), 1);
    end
    check("held_out_valid", int'(bus.out_valid), 1);
    check("held_dout", int'(bus.dOut), 1);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("held_ov_cycles", int'(n_ov_cycles - base >= 5), 1);
    check("out_valid_cleared", int'(bus.out_valid), 0);
    check("dout_retained", int'(bus.dOut), 1);

    // sOut_ready pattern 1,0,0 repeating; ordering and stability checked by the monitor
    for (int i = 0; i < 42; i++) begin
      bus.sOut_ready = (i % 3 == 0);
      tick();
    end
    bus.sIn_valid  = 1'b0;
    bus.sOut_ready = 1'b1;
    repeat (5) tick();
    check("stall_drain_empty", exp_q.size(), 0);
    check("stall_sout_idle", int'(bus.sOut_valid), 0);

    // Restart in PASS, next element 20
    wait_sig(2, "restart_ready");
    pulse_start();
    cnt = 8'd20; bus.sIn = cnt; bus.sIn_valid = 1'b1;
    wait_sig(0, "restart_head");
    check("restart_dout", int'(bus.dOut), 20);
    wait_sig(1, "restart_tail");
    check("restart_sout", int'(bus.sOut), 21);

    // Start together with an accept: that element goes to the tail, the next is the head
    bus.sIn_valid = 1'b0;
    repeat (4) tick();
    wait_sig(2, "simul_ready");
    cnt = 8'd30; bus.sIn = cnt; bus.sIn_valid = 1'b1;
    pulse_start();
    check("simul_sout_valid", int'(bus.sOut_valid), 1);
    check("simul_sout", int'(bus.sOut), 30);
    wait_sig(0, "simul_head");
    check("simul_dout", int'(bus.dOut), 31);

    // Data offered in IDLE is not consumed
    apply_reset();
    cnt = 8'd7; bus.sIn = cnt; bus.sIn_valid = 1'b1;
    repeat (3) begin
      tick();
      check("idle_sin_ready", int'(bus.sIn_ready), 0);
    end
    check("idle_not_consumed", int'(cnt), 7);
    pulse_start();
    wait_sig(0, "idle_head");
    check("idle_then_dout", int'(bus.dOut), 7);

    // Reset while sOut holds 5
    apply_reset();
    cnt = 8'd4; bus.sIn = cnt; bus.sOut_ready = 1'b0;
    pulse_start();
    wait_sig(1, "hold5");
    check("hold5_sout", int'(bus.sOut), 5);
    repeat (2) tick();
    apply_reset();
    bus.sOut_ready = 1'b1;
    base = n_sov_cycles;
    repeat (8) tick();
    check("no_stale_after_reset", n_sov_cycles - base, 0);
    pulse_start();
    wait_sig(1, "post_reset_tail");
    check("post_reset_not5", int'(bus.sOut == 8'd5), 0);

    // Randomized traffic against the model
    apply_reset();
    cnt = 8'd1; bus.sIn = cnt;
    repeat (1500) begin
      bus.in_valid   = ($urandom_range(0, 9) == 0);
      bus.sIn_valid  = ($urandom_range(0, 3) != 0);
      bus.sOut_ready = ($urandom_range(0, 2) != 0);
      bus.out_ready  = ($urandom_range(0, 1) != 0);
      tick();
    end
    bus.in_valid   = 1'b0;
    bus.sIn_valid  = 1'b0;
    bus.sOut_ready = 1'b1;
    bus.out_ready  = 1'b1;
    repeat (10) tick();
    check("rand_tail_drained", exp_q.size(), 0);
    check("rand_head_delivered", int'(dout_pending), 0);
    check("rand_sout_idle", int'(bus.sOut_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
